branch_resolve_unit: RTL and testbench

Parametrised branch resolution stage for the pipelined core's EX stage. Evaluates all six RV64 conditional-branch conditions at XLEN width and compares each outcome with the fetch-stage prediction. On a mispredict it issues a registered redirect and squashes the front end for a programmable number of cycles. Also keeps saturating branch and mispredict counters, and optionally a 2-bit bimodal predictor feeding fetch.

---
 rtl/bru_pkg.sv | 24 ++
 rtl/bru_bht.sv | 49 ++++
 rtl/branch_resolve_unit.sv | 131 +++++++++++++
 tb/tb_branch_resolve_unit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bru_pkg.sv
// Shared constants for the branch resolve unit: funct3 codes, FSM states,
// 2-bit predictor counter values and a funct3 legality helper.
package bru_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {IDLE, REDIRECT, SQUASH} bru_state_e;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Only 010 and 011 are reserved among the 3-bit branch codes.
  function automatic logic f3_legal(input logic [2:0] f3);
    return f3[2] | ~f3[1];
  endfunction

endpackage

// File: rtl/bru_bht.sv
// Bimodal branch history table: ENTRIES 2-bit saturating counters,
// indexed by pc[log2(ENTRIES)+1:2]; combinational read, registered update.
module bru_bht
  import bru_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int ENTRIES = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            upd_en,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] rd_pc,
  output logic            rd_taken
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0][1:0] ctr;
  logic [IDX_W-1:0]        upd_idx, rd_idx;
  logic [1:0]              cur, nxt;

  assign upd_idx = upd_pc[IDX_W+1:2];
  assign rd_idx  = rd_pc[IDX_W+1:2];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{upd_pc[XLEN-1:IDX_W+2], upd_pc[1:0],
                            rd_pc[XLEN-1:IDX_W+2], rd_pc[1:0]};

  always_comb begin
    cur = ctr[upd_idx];
    nxt = cur;
    if (upd_taken) begin
      if (cur != ST) nxt = cur + 2'd1;
    end else begin
      if (cur != SNT) nxt = cur - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ctr <= {ENTRIES{WNT}};
    else if (upd_en) ctr[upd_idx] <= nxt;
  end

  // Reads see the pre-update value when the same index is written this cycle.
  assign rd_taken = ctr[rd_idx][1];

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: condition evaluation, mispredict redirect,
// front-end squash FSM and perf counters. Optional predictor: BRU_BHT_EN.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_W       = 32,
  parameter int BHT_ENTRIES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic [2:0]       ex_funct3,
  input  logic [XLEN-1:0]  ex_rs1_data,
  input  logic [XLEN-1:0]  ex_rs2_data,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             ex_pred_taken,
  output logic             ex_ready,
  output logic             br_taken_q,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             squash,
  output logic             illegal_br,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count,
  input  logic [XLEN-1:0]  if_pc,
  output logic             if_pred_taken
);

  // SQUASH covers FLUSH_DEPTH-1 cycles; the counter holds cycles remaining after the current one.
  localparam int SQ_CYC = (FLUSH_DEPTH > 1) ? FLUSH_DEPTH - 2 : 0;
  localparam int CW     = (SQ_CYC > 1) ? $clog2(SQ_CYC + 1) : 1;
  localparam logic [CW-1:0] SQ_INIT = CW'(SQ_CYC);

  bru_state_e state, state_nxt;
  logic [CW-1:0] sq_cnt;

  logic accept, legal, taken, mispred;
  logic eq, lt_s, lt_u;

  assign ex_ready       = (state == IDLE);
  assign redirect_valid = (state == REDIRECT);
  assign squash         = (state != IDLE);

  assign accept  = ex_valid & ex_is_branch & ex_ready;
  assign legal   = f3_legal(ex_funct3);
  assign mispred = accept & legal & (taken != ex_pred_taken);

  assign eq   = (ex_rs1_data == ex_rs2_data);
  assign lt_s = ($signed(ex_rs1_data) < $signed(ex_rs2_data));
  assign lt_u = (ex_rs1_data < ex_rs2_data);

  always_comb begin
    taken = 1'b0;
    case (ex_funct3)
      F3_BEQ:  taken = eq;
      F3_BNE:  taken = ~eq;
      F3_BLT:  taken = lt_s;
      F3_BGE:  taken = ~lt_s;
      F3_BLTU: taken = lt_u;
      F3_BGEU: taken = ~lt_u;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (mispred) state_nxt = REDIRECT;
      REDIRECT: state_nxt = (FLUSH_DEPTH > 1) ? SQUASH : IDLE;
      SQUASH:   if (sq_cnt == '0) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                sq_cnt <= '0;
    else if (state == REDIRECT)  sq_cnt <= SQ_INIT;
    else if (state == SQUASH && sq_cnt != '0) sq_cnt <= sq_cnt - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      br_taken_q  <= 1'b0;
      illegal_br  <= 1'b0;
      redirect_pc <= '0;
    end else begin
      illegal_br <= accept & ~legal;
      if (accept) br_taken_q <= taken & legal;
      if (mispred) redirect_pc <= taken ? ex_target : ex_pc + XLEN'(4);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else begin
      if (accept && legal && br_count != '1) br_count <= br_count + CNT_W'(1);
      if (mispred && mispred_count != '1)   mispred_count <= mispred_count + CNT_W'(1);
    end
  end

`ifdef BRU_BHT_EN
  bru_bht #(
    .XLEN    (XLEN),
    .ENTRIES (BHT_ENTRIES)
  ) u_bht (
    .clk       (clk),
    .reset_n   (reset_n),
    .upd_en    (accept & legal),
    .upd_pc    (ex_pc),
    .upd_taken (taken),
    .rd_pc     (if_pc),
    .rd_taken  (if_pred_taken)
  );
`else
  assign if_pred_taken = 1'b0;
  logic unused_if_pc;
  assign unused_if_pc = ^if_pc;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized + directed bench for branch_resolve_unit against a cycle-level
// behavioural model (flush window count, counters, predictor table as ints).
module tb_branch_resolve_unit;

  localparam int XLEN = 64;
  localparam int FD   = 3;
  localparam int CW   = 4;
  localparam int NE   = 16;
  localparam int MAXC = (1 << CW) - 1;
`ifdef BRU_BHT_EN
  localparam bit BHT_ON = 1'b1;
`else
  localparam bit BHT_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset_n;
  logic            ex_valid, ex_is_branch, ex_pred_taken;
  logic [2:0]      ex_funct3;
  logic [XLEN-1:0] ex_rs1_data, ex_rs2_data, ex_pc, ex_target, if_pc;
  logic            ex_ready, br_taken_q, redirect_valid, squash, illegal_br, if_pred_taken;
  logic [XLEN-1:0] redirect_pc;
  logic [CW-1:0]   br_count, mispred_count;

  branch_resolve_unit #(.XLEN(XLEN), .FLUSH_DEPTH(FD), .CNT_W(CW), .BHT_ENTRIES(NE)) dut (
    .clk(clk), .reset_n(reset_n), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
    .ex_funct3(ex_funct3), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .ex_ready(ex_ready), .br_taken_q(br_taken_q), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .squash(squash), .illegal_br(illegal_br),
    .br_count(br_count), .mispred_count(mispred_count), .if_pc(if_pc),
    .if_pred_taken(if_pred_taken)
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0;

  // model state
  int              m_flush;
  bit              m_rv, m_tq, m_ill, last_acc;
  logic [XLEN-1:0] m_rpc;
  int              m_bc, m_mc;
  int              m_bht [NE];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_taken(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
    longint sa, sb;
    sa = a; sb = b;
    case (f)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int bidx(input logic [XLEN-1:0] pc);
    return int'((pc >> 2) % NE);
  endfunction

  task automatic model_reset();
    m_flush = 0; m_rv = 0; m_tq = 0; m_ill = 0; m_rpc = '0; m_bc = 0; m_mc = 0;
    for (int i = 0; i < NE; i++) m_bht[i] = 1;
  endtask

  task automatic set_br(input bit v, input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] pc, input logic [63:0] tgt, input bit pred);
    ex_valid = v; ex_is_branch = v; ex_funct3 = f; ex_rs1_data = a; ex_rs2_data = b;
    ex_pc = pc; ex_target = tgt; ex_pred_taken = pred;
  endtask

  // Called at posedge+1: check mid-cycle, advance model, clock.
  task automatic step();
    bit acc, lg, t;
    #3;
    chk("ex_ready",   ex_ready,       m_flush == 0);
    chk("squash",     squash,         m_flush > 0);
    chk("redir_vld",  redirect_valid, m_rv);
    chk("redir_pc",   redirect_pc,    m_rpc);
    chk("taken_q",    br_taken_q,     m_tq);
    chk("illegal",    illegal_br,     m_ill);
    chk("br_count",   br_count,       m_bc);
    chk("mis_count",  mispred_count,  m_mc);
    chk("if_pred",    if_pred_taken,  BHT_ON && (m_bht[bidx(if_pc)] >= 2));
    acc = ex_valid && ex_is_branch && (m_flush == 0);
    lg  = (ex_funct3 != 3'd2) && (ex_funct3 != 3'd3);
    t   = lg && ref_taken(ex_funct3, ex_rs1_data, ex_rs2_data);
    last_acc = acc;
    if (m_flush > 0) m_flush--;
    m_rv  = 0;
    m_ill = acc && !lg;
    if (acc) begin
      m_tq = t;
      if (lg) begin
        if (m_bc < MAXC) m_bc++;
        if (t && m_bht[bidx(ex_pc)] < 3) m_bht[bidx(ex_pc)]++;
        if (!t && m_bht[bidx(ex_pc)] > 0) m_bht[bidx(ex_pc)]--;
        if (t != ex_pred_taken) begin
          if (m_mc < MAXC) m_mc++;
          m_rv = 1; m_flush = FD;
          m_rpc = t ? ex_target : ex_pc + 64'd4;
        end
      end
    end
    @(posedge clk); #1;
  endtask

  // Offer the current branch until accepted, bounded.
  task automatic issue();
    for (int i = 0; i < 20; i++) begin
      step();
      if (last_acc) return;
    end
    chk("issue_timeout", 1'b0, 1'b1);
  endtask

  localparam logic [63:0] NEG1 = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    reset_n = 1'b0;
    if_pc = 64'h40;
    set_br(0, 3'd0, 0, 0, 0, 0, 0);
    model_reset();
    #3;
    chk("rst_ready",  ex_ready, 1'b1);
    chk("rst_squash", squash, 1'b0);
    chk("rst_rpc",    redirect_pc, 64'h0);
    chk("rst_bc",     br_count, 4'h0);
    #4 reset_n = 1'b1;
    @(posedge clk); #1;

    // beq equal, predicted taken: no redirect
    set_br(1, 3'd0, 64'h5, 64'h5, 64'h104, 64'h900, 1);
    issue();
    chk("beq_tq", br_taken_q, 1'b1);
    chk("beq_bc", br_count, 4'd1);
    chk("beq_rv", redirect_valid, 1'b0);
    chk("beq_rdy", ex_ready, 1'b1);

    // signed vs unsigned on (-1, 1)
    set_br(1, 3'd4, NEG1, 64'h1, 64'h10C, 64'h500, 0); issue();
    chk("blt_tq", br_taken_q, 1'b1);
    set_br(1, 3'd6, NEG1, 64'h1, 64'h10C, 64'h500, 0); issue();
    chk("bltu_tq", br_taken_q, 1'b0);
    set_br(1, 3'd5, NEG1, 64'h1, 64'h10C, 64'h500, 0); issue();
    chk("bge_tq", br_taken_q, 1'b0);
    set_br(1, 3'd7, NEG1, 64'h1, 64'h10C, 64'h500, 0); issue();
    chk("bgeu_tq", br_taken_q, 1'b1);

    // bne mispredicted not-taken, then a branch offered during squash
    set_br(1, 3'd1, 64'h1, 64'h2, 64'h208, 64'h1000, 0); issue();
    chk("bne_rv",  redirect_valid, 1'b1);
    chk("bne_rpc", redirect_pc, 64'h1000);
    chk("bne_sq",  squash, 1'b1);
    set_br(1, 3'd0, 64'h7, 64'h7, 64'h208, 64'h2000, 0);
    step(); step();
    chk("sq_n3", squash, 1'b1);
    chk("sq_rv_low", redirect_valid, 1'b0);
    set_br(0, 3'd0, 0, 0, 0, 0, 0);
    step();
    chk("sq_end", squash, 1'b0);
    chk("sq_bc", br_count, 4'd6);
    chk("sq_mc", mispred_count, 4'd3);

    // predicted taken, resolves not-taken at top of address space
    set_br(1, 3'd0, 64'h1, 64'h2, 64'hFFFF_FFFF_FFFF_FFFC, 64'h3000, 1); issue();
    chk("wrap_rpc", redirect_pc, 64'h0);
    set_br(0, 3'd0, 0, 0, 0, 0, 0);
    repeat (FD) step();

    // reserved funct3
    set_br(1, 3'd2, 64'h1, 64'h2, 64'h300, 64'h3000, 1); issue();
    chk("ill_pulse", illegal_br, 1'b1);
    chk("ill_rv", redirect_valid, 1'b0);
    chk("ill_bc", br_count, 4'd7);
    chk("ill_mc", mispred_count, 4'd4);
    set_br(0, 3'd0, 0, 0, 0, 0, 0); step();

    // predictor training at pc 0x40
    if_pc = 64'h40;
    #3 chk("bht_pre", if_pred_taken, 1'b0);
    #1 set_br(1, 3'd0, 64'h9, 64'h9, 64'h40, 64'h80, 1); issue();
    chk("bht_1", if_pred_taken, BHT_ON);
    issue();
    chk("bht_2", if_pred_taken, BHT_ON);
    issue();
    chk("bht_st", if_pred_taken, BHT_ON);

    // reset during squash
    set_br(1, 3'd1, 64'h1, 64'h2, 64'h400, 64'h4000, 0); issue();
    set_br(0, 3'd0, 0, 0, 0, 0, 0); step();
    #1 reset_n = 1'b0;
    #1;
    chk("arst_squash", squash, 1'b0);
    chk("arst_ready",  ex_ready, 1'b1);
    chk("arst_bc",     br_count, 4'h0);
    model_reset();
    #3 reset_n = 1'b1;
    @(posedge clk); #1;

    // mispredict counter saturation
    for (int i = 0; i < MAXC + 2; i++) begin
      set_br(1, 3'd1, 64'h1, 64'h2, 64'h500, 64'h5000, 0); issue();
    end
    set_br(0, 3'd0, 0, 0, 0, 0, 0); repeat (FD) step();
    chk("mc_sat", mispred_count, 4'hF);
    chk("bc_sat", br_count, 4'hF);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [63:0] a, b, pc;
      a = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = {$urandom, $urandom};
        2: b = NEG1;
        default: b = ~a;
      endcase
      pc = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 63)) << 2 : {$urandom, $urandom} & ~64'h3;
      if_pc = 64'($urandom_range(0, 63)) << 2;
      set_br($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), a, b, pc,
             {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      ex_is_branch = ex_valid && ($urandom_range(0, 7) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
